// File: rtl/dragonfang_floating_point_pkg.sv
// Floating-point vector unit types: beat width and mask sequencer states.
package dragonfang_floating_point_pkg;
  import dragonfang_pkg::*;

  localparam int unsigned BEAT_WIDTH = 64;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_RUN  = 1'b1
  } sequencer_state_t;

endpackage

// File: rtl/dragonfang_pkg.sv
// Shared decode types for the dragonfang vector pipeline.
package dragonfang_pkg;

  typedef enum logic [1:0] {
    DISABLED_MODE      = 2'd0,
    ENABLED_32BIT_MODE = 2'd1,
    ENABLED_64BIT_MODE = 2'd2,
    RESERVED_MODE      = 2'd3
  } bit_mode_t;

  localparam int unsigned OPCODE_WIDTH = 6;
  localparam int unsigned REG_WIDTH    = 5;

  typedef struct packed {
    logic [OPCODE_WIDTH-1:0] opcode;
    bit_mode_t               bit_mode;
    logic [REG_WIDTH-1:0]    vd;
    logic [REG_WIDTH-1:0]    vs1;
    logic [REG_WIDTH-1:0]    vs2;
  } execution_vector_t;

endpackage

// File: rtl/vector_floating_point_mask_sequencer.sv
// Walks a captured v0 mask over operand beats, one registered beat per
// handshake, feeding the merge unit with per-beat mask bits and lane enables.
module vector_floating_point_mask_sequencer
  import dragonfang_pkg::*;
  import dragonfang_floating_point_pkg::*;
#(
  parameter int unsigned MAX_ELEMENTS = 64,
  parameter int unsigned VL_WIDTH     = 7
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start_valid,
  output logic                    start_ready,
  input  execution_vector_t       execution_vector,
  input  logic [VL_WIDTH-1:0]     vl,
  input  logic [MAX_ELEMENTS-1:0] v0_mask,
  input  logic                    operand_valid,
  output logic                    operand_ready,
  input  logic [BEAT_WIDTH-1:0]   vs2_in,
  input  logic [BEAT_WIDTH-1:0]   vs1_in,
  output logic                    beat_valid,
  input  logic                    beat_ready,
  output execution_vector_t       beat_execution_vector,
  output logic [BEAT_WIDTH-1:0]   beat_v0,
  output logic [BEAT_WIDTH-1:0]   beat_vs2,
  output logic [BEAT_WIDTH-1:0]   beat_vs1,
  output logic [1:0]              beat_lane_enable,
  output logic                    beat_last,
  output logic                    done,
  output logic                    mode_error
);

  localparam int unsigned CW = VL_WIDTH + 1;

  sequencer_state_t        state, state_next;
  execution_vector_t       ev_q;
  logic [MAX_ELEMENTS-1:0] mask_q;
  logic [VL_WIDTH-1:0]     beats_remaining;
  logic                    odd_tail_q;

  logic                start_fire, operand_fire, drain_last;
  logic                mode_in_ok, mode_in_32, mode_q_32;
  logic [VL_WIDTH-1:0] vl_clamped, beat_count;
  logic                slice_last;
  logic [1:0]          slice_v0, slice_lane;

  assign start_ready   = (state == SEQ_IDLE);
  assign operand_ready = (state == SEQ_RUN) && (beats_remaining != '0) &&
                         (!beat_valid || beat_ready);

  // Next-state, handshake decode and current mask slice.
  always_comb begin
    state_next = state;
    start_fire   = start_valid && (state == SEQ_IDLE);
    operand_fire = operand_valid && operand_ready;
    drain_last   = beat_valid && beat_ready && beat_last;
    mode_in_32   = (execution_vector.bit_mode == ENABLED_32BIT_MODE);
    mode_in_ok   = mode_in_32 || (execution_vector.bit_mode == ENABLED_64BIT_MODE);
    mode_q_32    = (ev_q.bit_mode == ENABLED_32BIT_MODE);
    vl_clamped   = (32'(vl) > MAX_ELEMENTS) ? VL_WIDTH'(MAX_ELEMENTS) : vl;
    beat_count   = mode_in_32 ? VL_WIDTH'(({1'b0, vl_clamped} + CW'(1)) >> 1)
                              : vl_clamped;
    slice_last   = (beats_remaining == VL_WIDTH'(1));
    slice_v0     = {1'b0, mask_q[0]};
    slice_lane   = 2'b01;

    // Odd vl in 32-bit mode leaves the upper lane of the final beat as tail.
    if (mode_q_32) begin
      slice_v0[1] = mask_q[1] && !(slice_last && odd_tail_q);
      slice_lane  = (slice_last && odd_tail_q) ? 2'b01 : 2'b11;
    end

    case (state)
      SEQ_IDLE: if (start_fire && mode_in_ok && (beat_count != '0)) state_next = SEQ_RUN;
      SEQ_RUN:  if (drain_last) state_next = SEQ_IDLE;
      default:  state_next = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= SEQ_IDLE;
    else       state <= state_next;
  end

  // Operation capture, beat output register and completion pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ev_q                  <= '0;
      mask_q                <= '0;
      beats_remaining       <= '0;
      odd_tail_q            <= 1'b0;
      beat_valid            <= 1'b0;
      beat_execution_vector <= '0;
      beat_v0               <= '0;
      beat_vs2              <= '0;
      beat_vs1              <= '0;
      beat_lane_enable      <= '0;
      beat_last             <= 1'b0;
      done                  <= 1'b0;
      mode_error            <= 1'b0;
    end else begin
      done       <= 1'b0;
      mode_error <= 1'b0;

      if (start_fire) begin
        ev_q            <= execution_vector;
        mask_q          <= v0_mask;
        beats_remaining <= mode_in_ok ? beat_count : '0;
        odd_tail_q      <= mode_in_32 && vl_clamped[0];
        if (!mode_in_ok || (beat_count == '0)) begin
          done       <= 1'b1;
          mode_error <= !mode_in_ok;
        end
      end

      if (operand_fire) begin
        beats_remaining       <= beats_remaining - VL_WIDTH'(1);
        mask_q                <= mode_q_32 ? (mask_q >> 2) : (mask_q >> 1);
        beat_valid            <= 1'b1;
        beat_execution_vector <= ev_q;
        beat_v0               <= BEAT_WIDTH'(slice_v0);
        beat_vs2              <= vs2_in;
        beat_vs1              <= vs1_in;
        beat_lane_enable      <= slice_lane;
        beat_last             <= slice_last;
      end else if (beat_ready) begin
        beat_valid <= 1'b0;
      end

      if (drain_last) done <= 1'b1;
    end
  end

endmodule

// File: doc/vector_floating_point_mask_sequencer.md
VECTOR_FLOATING_POINT_MASK_SEQUENCER -- requirements
Module: vector_floating_point_mask_sequencer

Interface
REQ-001 Parameter MAX_ELEMENTS, default 64, meaning maximum element count per operation and width of the captured v0 mask.
REQ-002 Parameter VL_WIDTH, default 7, meaning width of vl, holding 0..MAX_ELEMENTS.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 Ports, one per line: name  direction  width  meaning.
 clock  in  1  sole clock, rising edge
 reset  in  1  asynchronous, active-high reset
 start_valid  in  1  new operation offered
 start_ready  out  1  sequencer idle, will accept operation
 execution_vector  in  execution_vector_t  decoded operation, bit_mode used
 vl  in  VL_WIDTH  element count
 v0_mask  in  MAX_ELEMENTS  full v0 mask, bit i governs element i
 operand_valid  in  1  one 64-bit operand beat offered
 operand_ready  out  1  beat accepted this cycle
 vs2_in, vs1_in  in  64 each  packed operand beat
 beat_valid  out  1  registered beat for merge unit valid
 beat_ready  in  1  downstream accepts beat
 beat_execution_vector  out  execution_vector_t  captured operation
 beat_v0  out  64  per-beat mask, bits [1:0] meaningful, rest zero
 beat_vs2, beat_vs1  out  64 each  registered operands
 beat_lane_enable  out  2  body-element lanes of this beat
 beat_last  out  1  final beat of operation
 done  out  1  one-cycle pulse at operation end
 mode_error  out  1  one-cycle pulse, unsupported bit_mode

Function
REQ-005 States SHALL be IDLE and RUN; start_ready=1 only in IDLE.
REQ-006 Start handshake (start_valid&&start_ready) SHALL capture execution_vector, vl, v0_mask and compute beat count: vl for ENABLED_64BIT_MODE, ceil(vl/2) for ENABLED_32BIT_MODE.
REQ-007 Beat count zero: remain IDLE, pulse done next cycle, emit no beats.
REQ-008 Any other bit_mode: remain IDLE, pulse mode_error and done next cycle, emit no beats.
REQ-009 Non-zero beat count: enter RUN next cycle.
REQ-010 operand_ready SHALL equal RUN && beats_remaining>0 && (!beat_valid || beat_ready).
REQ-011 On operand handshake, the output register SHALL load vs1_in, vs2_in, captured execution vector and the current mask slice; beat_valid=1 next cycle.
REQ-012 64-bit mode slice: beat_v0[0]=mask bit k, beat_v0[1]=0, lane_enable=2'b01; mask shifts right by 1.
REQ-013 32-bit mode slice: beat_v0[1:0]=mask bits {2k+1,2k}; mask shifts right by 2.
REQ-014 Tail: in 32-bit mode with odd vl, last beat SHALL force beat_v0[1]=0 and lane_enable=2'b01; otherwise lane_enable=2'b11.
REQ-015 beat_last=1 on the beat loaded when beats_remaining==1.
REQ-016 Held beat (beat_valid && !beat_ready) SHALL keep all beat_* outputs stable.
REQ-017 Accept of last beat downstream SHALL clear beat_valid, pulse done, return to IDLE same edge; new start accepted the following cycle.
REQ-018 Simultaneous drain and load SHALL replace the beat with no bubble (one beat per cycle sustained).
REQ-019 beats_remaining SHALL decrement only on operand handshake, never wrap below zero.
REQ-020 vl > MAX_ELEMENTS SHALL be clamped to MAX_ELEMENTS.

Reset
REQ-021 Reset SHALL force IDLE, beat_valid=0, done=0, mode_error=0, beats_remaining=0, beat_* data, mask register and lane_enable to zero, mid-operation included; the aborted operation is discarded.

Structure
REQ-022 execution_vector_t and bit_mode encodings SHALL come from dragonfang_pkg / dragonfang_floating_point_pkg; sequencer state enum SHALL be added to dragonfang_floating_point_pkg.
REQ-023 No sub-module; beat_* outputs feed vector_floating_point_merge_unit directly (v0, vs2, vs1).

Verification
REQ-024 64-bit mode, vl=3, v0_mask=0b101, beat_ready=1 -> 3 beats, beat_v0[0]=1,0,1, beat_last on 3rd, done next cycle.
REQ-025 32-bit mode, vl=3, v0_mask=0b1111 -> 2 beats, beat_v0[1:0]=11 then 01, lane_enable 11 then 01.
REQ-026 beat_ready low 4 cycles on beat 2 -> outputs stable, operand_ready=0, no beat lost or duplicated.
REQ-027 vl=0, then bit_mode invalid -> done pulse each, mode_error only on second, no beat_valid.
REQ-028 Reset asserted during beat 2 of vl=8 -> all outputs zero immediately, IDLE, next start runs full 8 beats.
